// File: rtl/i2c_temp_responder_pkg.sv
// Shared types and constants for the I2C temperature responder.
// Imported by the line filter and the top-level responder.
package i2c_temp_responder_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    TX_BYTE,
    RX_MACK,
    RX_BYTE,
    RX_ACK,
    WAIT_STOP
  } state_e;

  localparam logic [6:0] DEF_ADDR   = 7'h4B;
  localparam int         FILT_DEPTH = 3;
  localparam int         NUM_BYTES  = 2;

endpackage

// File: rtl/i2c_temp_responder_line_filter.sv
// Two-flop synchronizer plus majority filter for one I2C line.
// Edge pulses are combinational, one cycle ahead of the filt level.
module i2c_line_filter
  import i2c_temp_responder_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic filt,
  output logic rise,
  output logic fall
);

  localparam int CW = $clog2(FILT_DEPTH + 1);

  logic [1:0]            sync_q, sync_d;
  logic [FILT_DEPTH-1:0] samp_q, samp_d;
  logic                  filt_q, filt_d;
  logic [CW-1:0]         ones;

  always_comb begin
    sync_d = {sync_q[0], din};
    samp_d = {samp_q[FILT_DEPTH-2:0], sync_q[1]};
    ones   = '0;
    for (int i = 0; i < FILT_DEPTH; i++) begin
      ones = ones + CW'(samp_q[i]);
    end
    filt_d = (ones > CW'(FILT_DEPTH / 2));
  end

  // Idle bus is high, so reset everything to 1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '1;
      samp_q <= '1;
      filt_q <= 1'b1;
    end else begin
      sync_q <= sync_d;
      samp_q <= samp_d;
      filt_q <= filt_d;
    end
  end

  assign filt = filt_q;
  assign rise = filt_d & ~filt_q;
  assign fall = ~filt_d & filt_q;

endmodule

// File: rtl/i2c_temp_responder.sv
// I2C target that serves a latched 16-bit temperature word (MSB first)
// and stores the last register-pointer byte written by the master.
module i2c_temp_responder
  import i2c_temp_responder_pkg::*;
#(
  parameter logic [6:0]  SLAVE_ADDR = DEF_ADDR,
  parameter logic [15:0] TEMP_RESET = 16'h0000
) (
  input  logic        clk_100MHz,
  input  logic        reset,
  input  logic        SCL,
  input  logic        SDA_in,
  output logic        SDA_oe,
  input  logic [15:0] temp_in,
  output logic [7:0]  pointer,
  output logic        busy,
  output logic        rd_done
);

  logic scl_f, scl_rise, scl_fall;
  logic sda_f, sda_rise, sda_fall;
  logic start, stop;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [7:0]  shreg_q, shreg_d;
  logic [15:0] shadow_q, shadow_d;
  logic [7:0]  pointer_q, pointer_d;
  logic        byte_sel_q, byte_sel_d;
  logic        rw_q, rw_d;
  logic        phase_q, phase_d;
  logic        oe_q, oe_d;
  logic        busy_q, busy_d;
  logic        rd_done_q, rd_done_d;
  logic [7:0]  tx_byte;

  i2c_line_filter u_scl (
    .clk  (clk_100MHz),
    .rst_n(reset),
    .din  (SCL),
    .filt (scl_f),
    .rise (scl_rise),
    .fall (scl_fall)
  );

  i2c_line_filter u_sda (
    .clk  (clk_100MHz),
    .rst_n(reset),
    .din  (SDA_in),
    .filt (sda_f),
    .rise (sda_rise),
    .fall (sda_fall)
  );

  assign start   = sda_fall & scl_f;
  assign stop    = sda_rise & scl_f;
  assign tx_byte = byte_sel_q ? shadow_q[7:0] : shadow_q[15:8];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shreg_d    = shreg_q;
    shadow_d   = shadow_q;
    pointer_d  = pointer_q;
    byte_sel_d = byte_sel_q;
    rw_d       = rw_q;
    phase_d    = phase_q;
    oe_d       = oe_q;
    busy_d     = busy_q;
    rd_done_d  = 1'b0;
    // Bus conditions take priority over any same-cycle SCL edge.
    if (start) begin
      state_d = ADDR;
      cnt_d   = '0;
      phase_d = 1'b0;
      oe_d    = 1'b0;
    end else if (stop) begin
      state_d = IDLE;
      cnt_d   = '0;
      phase_d = 1'b0;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: ;
        ADDR: begin
          if (scl_rise) begin
            shreg_d = {shreg_q[6:0], sda_f};
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              if (shreg_q[6:0] == SLAVE_ADDR) begin
                state_d    = ADDR_ACK;
                busy_d     = 1'b1;
                rw_d       = sda_f;
                byte_sel_d = 1'b0;
                if (sda_f) shadow_d = temp_in;
              end else begin
                state_d = WAIT_STOP;
                busy_d  = 1'b0;
              end
            end
          end
        end
        ADDR_ACK, RX_ACK: begin
          if (scl_fall) begin
            if (!phase_q) begin
              oe_d    = 1'b1;
              phase_d = 1'b1;
            end else if (state_q == ADDR_ACK && rw_q) begin
              phase_d = 1'b0;
              state_d = TX_BYTE;
              oe_d    = ~shadow_q[15];
              cnt_d   = 3'd1;
            end else begin
              phase_d = 1'b0;
              state_d = RX_BYTE;
              oe_d    = 1'b0;
              cnt_d   = '0;
            end
          end
        end
        TX_BYTE: begin
          if (scl_fall) begin
            if (cnt_q == 3'd0) begin
              state_d = RX_MACK;
              oe_d    = 1'b0;
            end else begin
              oe_d  = ~tx_byte[3'd7 - cnt_q];
              cnt_d = cnt_q + 3'd1;
            end
          end
        end
        RX_MACK: begin
          if (scl_rise) begin
            if (byte_sel_q == 1'(NUM_BYTES - 1)) begin
              rd_done_d = 1'b1;
              state_d   = WAIT_STOP;
            end else if (sda_f) begin
              state_d = WAIT_STOP;
            end else begin
              phase_d = 1'b1;
            end
          end else if (scl_fall && phase_q) begin
            phase_d    = 1'b0;
            byte_sel_d = 1'b1;
            state_d    = TX_BYTE;
            oe_d       = ~shadow_q[7];
            cnt_d      = 3'd1;
          end
        end
        RX_BYTE: begin
          if (scl_rise) begin
            shreg_d = {shreg_q[6:0], sda_f};
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              pointer_d = {shreg_q[6:0], sda_f};
              state_d   = RX_ACK;
            end
          end
        end
        WAIT_STOP: oe_d = 1'b0;
        default:   state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_100MHz) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      shreg_q    <= '0;
      shadow_q   <= TEMP_RESET;
      pointer_q  <= '0;
      byte_sel_q <= 1'b0;
      rw_q       <= 1'b0;
      phase_q    <= 1'b0;
      oe_q       <= 1'b0;
      busy_q     <= 1'b0;
      rd_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shreg_q    <= shreg_d;
      shadow_q   <= shadow_d;
      pointer_q  <= pointer_d;
      byte_sel_q <= byte_sel_d;
      rw_q       <= rw_d;
      phase_q    <= phase_d;
      oe_q       <= oe_d;
      busy_q     <= busy_d;
      rd_done_q  <= rd_done_d;
    end
  end

  assign SDA_oe  = oe_q;
  assign busy    = busy_q;
  assign rd_done = rd_done_q;
  assign pointer = pointer_q;

endmodule
